// File: rtl/fetch_pc_ctrl_if.sv
// IMEM read port between the fetch PC engine (master) and the per-core instruction memory (slave).
// One request is accepted on req && ready; exactly one rvalid beat answers it later.
interface fetch_pc_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// PC generator and IMEM read engine feeding ins_fetch through a 2-entry buffer.
// rvalid at cycle t shows as instr_valid_out at t+1; stall_in holds the head and stops refills when full.
// Redirect flushes the buffer and drops the one stale response still owed by memory.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_in,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    fetch_pc_ctrl_if.master        imem,
    output logic [31:0]            pc_out,
    output logic [31:0]            instr_out,
    output logic                   instr_valid_out,
    output logic                   fetch_misaligned
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        kill_q;
    logic        misalign_q;
    logic [31:0] hd_pc_q, hd_ins_q, tl_pc_q, tl_ins_q;
    logic        push, pop;

    always_comb begin
        pop     = (count_q != 2'd0) && !stall_in && !redirect_valid;
        push    = (state_q == S_WAIT) && imem.imem_rvalid && !kill_q && !redirect_valid;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                case (state_q)
                    // A response is still owed: stay until it arrives, unless it is arriving now.
                    S_WAIT: begin
                        if (imem.imem_rvalid) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            kill_q  <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        kill_q  <= 1'b1;
                        state_q <= imem.imem_ready ? S_WAIT : S_REQ;
                    end
                    default: state_q <= S_REQ;
                endcase
            end else begin
                case (state_q)
                    S_IDLE: if (count_q < 2'd2) state_q <= S_REQ;
                    S_REQ:  if (imem.imem_ready) state_q <= S_WAIT;
                    S_WAIT: begin
                        if (imem.imem_rvalid) begin
                            if (kill_q) begin
                                kill_q  <= 1'b0;
                                state_q <= S_REQ;
                            end else begin
                                fetch_pc_q <= fetch_pc_q + 32'd4;
                                state_q    <= (count_d < 2'd2) ? S_REQ : S_IDLE;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= 2'd0;
            hd_pc_q  <= 32'd0;
            hd_ins_q <= 32'd0;
            tl_pc_q  <= 32'd0;
            tl_ins_q <= 32'd0;
        end else begin
            count_q <= redirect_valid ? 2'd0 : count_d;
            if (push && ((count_q == 2'd0) || (count_q == 2'd1 && pop))) begin
                hd_pc_q  <= fetch_pc_q;
                hd_ins_q <= imem.imem_rdata;
            end else if (push && (count_q == 2'd1)) begin
                tl_pc_q  <= fetch_pc_q;
                tl_ins_q <= imem.imem_rdata;
            end else if (pop && (count_q == 2'd2)) begin
                hd_pc_q  <= tl_pc_q;
                hd_ins_q <= tl_ins_q;
                if (push) begin
                    tl_pc_q  <= fetch_pc_q;
                    tl_ins_q <= imem.imem_rdata;
                end
            end
        end
    end

    assign imem.imem_req    = (state_q == S_REQ);
    assign imem.imem_addr   = fetch_pc_q;
    assign instr_valid_out  = (count_q != 2'd0);
    assign pc_out           = instr_valid_out ? hd_pc_q : fetch_pc_q;
    assign instr_out        = instr_valid_out ? hd_ins_q : NOP_INSTR;
    assign fetch_misaligned = misalign_q;
endmodule
